// File: rtl/cpu24_pkg.sv
// cpu24_pkg: shared definitions for the CPU24/VCPU-32 core datapath.
//   WORD_LENGTH : native word width in bits.
//   word_t      : one core word, bit 0 is the MSB.
//   is_all_ones : helper returning 1 when every bit of a word is set.
package cpu24_pkg;

  localparam int WORD_LENGTH = 24;

  typedef logic [0:WORD_LENGTH-1] word_t;

  function automatic logic is_all_ones(input word_t w);
    return &w;
  endfunction

endpackage

// File: rtl/incr_core.sv
// incr_core: purely combinational WIDTH-bit incrementer, {outC, s} = a + 1.
// Ports:
//   a    in  [0:WIDTH-1]  operand, bit 0 is the MSB
//   s    out [0:WIDTH-1]  (a + 1) mod 2^WIDTH
//   outC out 1            carry-out, set only when a is all ones
// A bit toggles when every less-significant bit is 1. Those "all ones
// below" terms come from a Kogge-Stone style prefix AND tree of
// ceil(log2(WIDTH)) levels, followed by a single XOR stage.
module incr_core
  import cpu24_pkg::*;
#(
  parameter int WIDTH = WORD_LENGTH
) (
  input  logic [0:WIDTH-1] a,
  output logic [0:WIDTH-1] s,
  output logic             outC
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Internal little-endian view: index k = 0 is the LSB (a[WIDTH-1]).
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] pre;     // pre[k] = AND of b[0..k]
  logic [WIDTH-1:0] sum_le;

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      b[k] = a[WIDTH-1-k];
    end
  end

  // Each level combines spans that are 2^l apart, so the unrolled loop
  // gives a log-depth tree rather than a ripple chain.
  always_comb begin
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    cur = b;
    nxt = b;
    for (int l = 0; l < LEVELS; l++) begin
      nxt = cur;
      for (int k = 0; k < WIDTH; k++) begin
        if (k >= (1 << l)) begin
          nxt[k] = cur[k] & cur[k-(1<<l)];
        end
      end
      cur = nxt;
    end
    pre = cur;
  end

  // The LSB always toggles; bit k toggles when bits 0..k-1 are all ones.
  always_comb begin
    sum_le = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k == 0) begin
        sum_le[k] = ~b[k];
      end else begin
        sum_le[k] = b[k] ^ pre[k-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      s[WIDTH-1-k] = sum_le[k];
    end
  end

  assign outC = pre[WIDTH-1];

endmodule

// File: rtl/incrementer.sv
// incrementer: registered WIDTH-bit incrementer with carry-out.
// Ports:
//   clk       in  1            rising-edge clock
//   rst_n     in  1            asynchronous active-low reset
//   in_valid  in  1            operand on a is valid this cycle
//   a         in  [0:WIDTH-1]  operand, bit 0 is the MSB
//   out_valid out 1            s/outC hold a new result
//   s         out [0:WIDTH-1]  registered (a + 1) mod 2^WIDTH
//   outC      out 1            registered carry-out (a was all ones)
// One cycle latency, one result per cycle, no backpressure. Outputs are
// driven straight from flops.
module incrementer
  import cpu24_pkg::*;
#(
  parameter int WIDTH = WORD_LENGTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [0:WIDTH-1] a,
  output logic             out_valid,
  output logic [0:WIDTH-1] s,
  output logic             outC
);

  logic [0:WIDTH-1] sum_c;
  logic             carry_c;

  logic [0:WIDTH-1] s_d,         s_q;
  logic             outc_d,      outc_q;
  logic             out_valid_d, out_valid_q;

  incr_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (a),
    .s    (sum_c),
    .outC (carry_c)
  );

  // Load on a valid operand, otherwise hold the last result; out_valid
  // marks only the cycle right after an accepted operand.
  always_comb begin
    s_d         = s_q;
    outc_d      = outc_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum_c;
      outc_d      = carry_c;
      out_valid_d = 1'b1;
    end
  end

  // ---- stage boundary: combinational sum -> result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      outc_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      outc_q      <= outc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign outC      = outc_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_incrementer.sv
// tb_incrementer: directed and random checks of the registered incrementer.
module tb_incrementer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [0:23] a;
  logic        out_valid;
  logic [0:23] s;
  logic        outC;

  int tests;
  int fails;

  incrementer #(
    .WIDTH (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .s         (s),
    .outC      (outC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "simulation timeout");
  end

  // Compare {out_valid, outC, s} against the expected triple.
  task automatic chk(input string tag, input logic ev, input logic ec,
                     input logic [23:0] es);
    logic [25:0] obs;
    logic [25:0] exp;
    obs = {out_valid, outC, s};
    exp = {ev, ec, es};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed vld=%b c=%b s=%h expected vld=%b c=%b s=%h",
             tag, obs[25], obs[24], obs[23:0], exp[25], exp[24], exp[23:0]);
    end
  endtask

  // Drive one cycle of input after the falling edge, then sample just
  // after the following rising edge.
  task automatic step(input logic v, input logic [23:0] av);
    @(negedge clk);
    in_valid = v;
    a        = av;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] r;
    logic [24:0] e;
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;

    // Reset state
    #12;
    chk("reset_init", 1'b0, 1'b0, 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic increments
    step(1'b1, 24'h000000); chk("inc_0",   1'b1, 1'b0, 24'h000001);
    step(1'b1, 24'h00000A); chk("inc_A",   1'b1, 1'b0, 24'h00000B);

    // Asynchronous reset in mid-cycle clears immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 1'b0, 1'b0, 24'h000000);
    step(1'b1, 24'h123456); chk("reset_hold", 1'b0, 1'b0, 24'h000000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("reset_release", 1'b0, 1'b0, 24'h000000);

    // Wrap-around and long carry chains
    step(1'b1, 24'hFFFFFF); chk("wrap",    1'b1, 1'b1, 24'h000000);
    step(1'b1, 24'h7FFFFF); chk("carry23", 1'b1, 1'b0, 24'h800000);
    step(1'b1, 24'h0000FF); chk("carry8",  1'b1, 1'b0, 24'h000100);
    step(1'b1, 24'hFFFF7F); chk("carry7",  1'b1, 1'b0, 24'hFFFF80);

    // Back-to-back stream
    step(1'b1, 24'hFFFFFE); chk("b2b_0",   1'b1, 1'b0, 24'hFFFFFF);
    step(1'b1, 24'hFFFFFF); chk("b2b_1",   1'b1, 1'b1, 24'h000000);
    step(1'b1, 24'h000000); chk("b2b_2",   1'b1, 1'b0, 24'h000001);

    // Idle cycle with X operand: out_valid drops, result held
    step(1'b1, 24'hABCDEF); chk("pre_idle", 1'b1, 1'b0, 24'hABCDF0);
    step(1'b0, 24'hxxxxxx); chk("idle",     1'b0, 1'b0, 24'hABCDF0);
    step(1'b0, 24'hxxxxxx); chk("idle2",    1'b0, 1'b0, 24'hABCDF0);

    // Reset pulse covering an edge with an operand pending: it is lost
    @(negedge clk);
    in_valid = 1'b1;
    a        = 24'h555554;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("lost_inflight", 1'b0, 1'b0, 24'h000000);
    step(1'b1, 24'h800000); chk("after_reset", 1'b1, 1'b0, 24'h800001);

    // Random sweep
    for (int i = 0; i < 10000; i++) begin
      r = 24'($urandom);
      if (i == 0) r = 24'hFFFFFF;
      e = {1'b0, r} + 25'd1;
      step(1'b1, r);
      chk("random", 1'b1, e[24], e[23:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/incrementer.md
# incrementer

Registered WIDTH-bit incrementer: computes a + 1 with a carry-out flag and presents the result one clock after the operand is accepted. It is a shared datapath utility in the CPU24/VCPU-32 core, used for program-counter and address-stepping paths. It is the word-length companion to the adder. Bit numbering follows the core convention: bit 0 is the MSB.

## Interface
- WIDTH, default 24 (`WORD_LENGTH`): operand and result width in bits.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Reset, asynchronous and active-low.
- in_valid  in  1  Operand on `a` is valid this cycle.
- a  in  [0:WIDTH-1]  Operand; bit 0 is the MSB.
- out_valid  out  1  `s`/`outC` hold a new result.
- s  out  [0:WIDTH-1]  Registered sum, (a + 1) mod 2^WIDTH.
- outC  out  1  Registered carry-out; 1 only when `a` was all ones.

## Operation
- Arithmetic: {outC, s} = {1'b0, a} + 1, computed over WIDTH+1 bits. There is no signed interpretation.
- `a` = all ones gives `s` = 0 and `outC` = 1.
- Any other `a` gives `s` = a + 1 and `outC` = 0.
- Invariant: `outC` = 1 implies `s` = 0.
- Carry logic:
  - bit i toggles iff all less-significant bits (i+1 .. WIDTH-1) of `a` are 1;
  - the LSB (bit WIDTH-1) always toggles;
  - `outC` = AND of all bits of `a`.
- Carry structure: a parallel-prefix AND tree with log2(WIDTH) levels. A ripple chain is not allowed.
- Result registers:
  - on a clock edge with in_valid = 1, `s`/`outC` load the combinational result and out_valid is set to 1;
  - on a clock edge with in_valid = 0, out_valid is set to 0 and `s`/`outC` hold their previous values.
- There is no stall or backpressure. One operand can be accepted every cycle, and results are never dropped or reordered.
- Reset (rst_n = 0) forces `s` = 0, `outC` = 0, out_valid = 0 immediately, without waiting for clk, and holds them there while rst_n is low.
- Reset mid-operation: a result in flight is discarded. The first edge after release with in_valid = 1 produces the next valid result.
- `a` is X while in_valid = 0: no effect on outputs.

## Timing
- Latency is 1 cycle: an operand sampled at edge N is visible on `s`/`outC`/out_valid after edge N.
- Throughput is 1 result per cycle.
- The combinational path from `a` to the register inputs is one prefix tree plus the XOR stage. For WIDTH = 24 this is 5 AND levels + 1 XOR, and it must close within one clk period.
- Reset assertion is asynchronous. Deassertion is synchronized externally by the system; the block does not synchronize it.
- Outputs are register-driven only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `cpu24_pkg`: `WORD_LENGTH` (= 24) and a word typedef [0:WORD_LENGTH-1].
- Sub-module `incr_core`, purely combinational: `a` -> `s`, `outC`, containing the prefix AND tree and the XOR stage, parameterised by WIDTH.
- The top level holds the `incr_core` instance, the result/carry registers and the out_valid flop.

## Test plan
- Reset: drive rst_n = 0 mid-cycle -> `s` = 0, `outC` = 0, out_valid = 0 immediately; values hold through release.
- Basic increments:
  - a = 0x000000, in_valid = 1 -> next cycle `s` = 0x000001, `outC` = 0, out_valid = 1;
  - a = 0x00000A -> `s` = 0x00000B, `outC` = 0.
- Wrap-around: a = 0xFFFFFF -> `s` = 0x000000, `outC` = 1.
- Long carry chain:
  - a = 0x7FFFFF -> `s` = 0x800000, `outC` = 0;
  - a = 0x0000FF -> `s` = 0x000100.
- Back-to-back: stream 0xFFFFFE, 0xFFFFFF, 0x000000 on consecutive cycles -> results 0xFFFFFF/0, 0x000000/1, 0x000001/0 on consecutive cycles.
- Idle and reset mid-stream:
  - in_valid = 0 for one cycle -> out_valid = 0 with `s` held;
  - rst_n pulse between operands -> in-flight result lost and outputs 0 until the next valid operand.
- Random sweep: 10k random `a` -> {outC, s} == a + 1 over 25 bits, every result.
